// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter: picks one eligible slave FIFO and streams one packet to the formatter.
// Optional MCDF_ARB_RR_EN: round-robin tie-break among equal-priority channels.
module mcdf_arbiter #(
  parameter int FIFO_DEPTH = 63
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slv0_en_i,
  input  logic        slv1_en_i,
  input  logic        slv2_en_i,
  input  logic [1:0]  slv0_prio_i,
  input  logic [1:0]  slv1_prio_i,
  input  logic [1:0]  slv2_prio_i,
  input  logic [2:0]  slv0_pkglen_i,
  input  logic [2:0]  slv1_pkglen_i,
  input  logic [2:0]  slv2_pkglen_i,
  input  logic [5:0]  slv0_margin_i,
  input  logic [5:0]  slv1_margin_i,
  input  logic [5:0]  slv2_margin_i,
  input  logic [31:0] slv0_data_i,
  input  logic [31:0] slv1_data_i,
  input  logic [31:0] slv2_data_i,
  output logic        slv0_ack_o,
  output logic        slv1_ack_o,
  output logic        slv2_ack_o,
  input  logic        fmt_grant_i,
  output logic        fmt_req_o,
  output logic [1:0]  fmt_chid_o,
  output logic [5:0]  fmt_length_o,
  output logic        fmt_send_o,
  output logic [31:0] fmt_data_o,
  output logic        fmt_start_o,
  output logic        fmt_end_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  localparam logic [6:0] DEPTH = 7'(FIFO_DEPTH);

  logic [2:0] en;
  logic [1:0] prio [3];
  logic [2:0] plen [3];
  logic [5:0] margin [3];
  logic [5:0] occ [3];
  logic [2:0] elig;

  logic [1:0] state;
  logic [1:0] chid;
  logic [5:0] len;
  logic [5:0] cnt;
  logic       last;

  logic [1:0] start;
  logic [1:0] win;
  logic [1:0] best;
  logic       found;
  logic [2:0] c3;

  assign en        = {slv2_en_i, slv1_en_i, slv0_en_i};
  assign prio[0]   = slv0_prio_i;
  assign prio[1]   = slv1_prio_i;
  assign prio[2]   = slv2_prio_i;
  assign plen[0]   = slv0_pkglen_i;
  assign plen[1]   = slv1_pkglen_i;
  assign plen[2]   = slv2_pkglen_i;
  assign margin[0] = slv0_margin_i;
  assign margin[1] = slv1_margin_i;
  assign margin[2] = slv2_margin_i;

  function automatic logic [5:0] dec_len(input logic [2:0] code);
    case (code)
      3'd0:    return 6'd4;
      3'd1:    return 6'd8;
      3'd2:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if ({1'b0, margin[i]} > DEPTH) occ[i] = '0;
      else occ[i] = 6'(DEPTH - {1'b0, margin[i]});
      elig[i] = en[i] && (occ[i] >= dec_len(plen[i]));
    end
  end

`ifdef MCDF_ARB_RR_EN
  logic [1:0] ptr;
  assign start = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
`else
  assign start = 2'd0;
`endif

  // strict '<' keeps the earliest channel in search order on a priority tie
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    best  = 2'd3;
    c3    = 3'd0;
    for (int k = 0; k < 3; k++) begin
      c3 = {1'b0, start} + 3'(k);
      if (c3 > 3'd2) c3 = c3 - 3'd3;
      if (elig[c3[1:0]] && (!found || prio[c3[1:0]] < best)) begin
        found = 1'b1;
        win   = c3[1:0];
        best  = prio[c3[1:0]];
      end
    end
  end

  assign last = (cnt == len - 6'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      chid  <= '0;
      len   <= '0;
      cnt   <= '0;
`ifdef MCDF_ARB_RR_EN
      ptr   <= 2'd2;
`endif
    end else begin
      unique case (state)
        S_IDLE: if (|elig) state <= S_ARB;
        S_ARB: begin
          if (found) begin
            chid  <= win;
            len   <= dec_len(plen[win]);
            state <= S_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (fmt_grant_i) begin
            cnt   <= '0;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (last) begin
            cnt   <= '0;
            state <= S_IDLE;
`ifdef MCDF_ARB_RR_EN
            ptr   <= chid;
`endif
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic in_req;
  logic in_send;

  assign in_req  = (state == S_REQ);
  assign in_send = (state == S_SEND);

  assign fmt_req_o    = in_req;
  assign fmt_send_o   = in_send;
  assign fmt_chid_o   = (in_req || in_send) ? chid : 2'd0;
  assign fmt_length_o = (in_req || in_send) ? len : 6'd0;
  assign fmt_start_o  = in_send && (cnt == 6'd0);
  assign fmt_end_o    = in_send && last;
  assign slv0_ack_o   = in_send && (chid == 2'd0);
  assign slv1_ack_o   = in_send && (chid == 2'd1);
  assign slv2_ack_o   = in_send && (chid == 2'd2);

  always_comb begin
    fmt_data_o = '0;
    if (in_send) begin
      unique case (chid)
        2'd0:    fmt_data_o = slv0_data_i;
        2'd1:    fmt_data_o = slv1_data_i;
        2'd2:    fmt_data_o = slv2_data_i;
        default: fmt_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// tb_mcdf_arbiter: vector table for arbitration plus scoreboarded packet sequences.
// FIFO model pops on ack; expected beats are queued when each scenario is set up.
module tb_mcdf_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] en;
  logic [1:0] prio [3];
  logic [2:0] plen [3];
  int         fill [3];
  int         pops [3];
  int         ack_total [3];
  logic       grant;
  logic       auto_grant;
  logic       grant_force;
  int         rcnt;

  logic [5:0]  m0, m1, m2;
  logic [31:0] d0, d1, d2;
  logic        a0, a1, a2;
  logic        req, send, st, en_d;
  logic [1:0]  chid;
  logic [5:0]  flen;
  logic [31:0] fdata;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] word(int ch, int i);
    return {8'hA0 + 8'(ch), 8'h5A, 16'(i)};
  endfunction

  assign m0 = 6'(63 - (fill[0] - pops[0]));
  assign m1 = 6'(63 - (fill[1] - pops[1]));
  assign m2 = 6'(63 - (fill[2] - pops[2]));
  assign d0 = word(0, pops[0]);
  assign d1 = word(1, pops[1]);
  assign d2 = word(2, pops[2]);

  mcdf_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .slv0_en_i(en[0]), .slv1_en_i(en[1]), .slv2_en_i(en[2]),
    .slv0_prio_i(prio[0]), .slv1_prio_i(prio[1]), .slv2_prio_i(prio[2]),
    .slv0_pkglen_i(plen[0]), .slv1_pkglen_i(plen[1]),
    .slv2_pkglen_i(plen[2]),
    .slv0_margin_i(m0), .slv1_margin_i(m1), .slv2_margin_i(m2),
    .slv0_data_i(d0), .slv1_data_i(d1), .slv2_data_i(d2),
    .slv0_ack_o(a0), .slv1_ack_o(a1), .slv2_ack_o(a2),
    .fmt_grant_i(grant), .fmt_req_o(req), .fmt_chid_o(chid),
    .fmt_length_o(flen), .fmt_send_o(send), .fmt_data_o(fdata),
    .fmt_start_o(st), .fmt_end_o(en_d)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [5:0]  len;
    logic [31:0] data;
    logic        st;
    logic        en;
    logic [2:0]  ack;
  } beat_t;

  beat_t sb [$];
  int    exp_idx [3];
  logic  sb_on;

  // formatter: grant one cycle after req is first seen
  always @(negedge clk) begin
    if (req) rcnt = rcnt + 1;
    else rcnt = 0;
    grant = grant_force || (auto_grant && req && rcnt >= 2);
  end

  // monitor first, then FIFO pop, so show-ahead data moves after sampling
  always @(negedge clk) begin
    beat_t act, e;
    if (!rst) begin
      checks++;
      if (($countones({a2, a1, a0}) > 1) || ({a2, a1, a0} != 0 && !send)
          || ((st || en_d) && !send)) begin
        errors++;
        $display("FAIL strobes: ack=%b send=%b start=%b end=%b",
                 {a2, a1, a0}, send, st, en_d);
      end
      if (send && sb_on) begin
        act = '{chid, flen, fdata, st, en_d, {a2, a1, a0}};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat: unexpected beat ch=%0d data=%h", chid, fdata);
        end else begin
          e = sb.pop_front();
          if (act != e) begin
            errors++;
            $display("FAIL beat: got ch=%0d len=%0d data=%h st=%b end=%b ack=%b, want ch=%0d len=%0d data=%h st=%b end=%b ack=%b",
                     act.ch, act.len, act.data, act.st, act.en, act.ack,
                     e.ch, e.len, e.data, e.st, e.en, e.ack);
          end
        end
      end
    end
    if (a0) begin pops[0]++; ack_total[0]++; end
    if (a1) begin pops[1]++; ack_total[1]++; end
    if (a2) begin pops[2]++; ack_total[2]++; end
  end

  task automatic expect_pkt(int ch, int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.ch   = 2'(ch);
      b.len  = 6'(len);
      b.data = word(ch, exp_idx[ch]);
      b.st   = (i == 0);
      b.en   = (i == len - 1);
      b.ack  = 3'(1 << ch);
      sb.push_back(b);
      exp_idx[ch]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(string name);
    checks++;
    if ({req, chid, flen, send, fdata, st, en_d, a0, a1, a2} != 0) begin
      errors++;
      $display("FAIL %s: outputs req=%b ch=%0d len=%0d send=%b data=%h st=%b end=%b ack=%b, want all 0",
               name, req, chid, flen, send, fdata, st, en_d, {a2, a1, a0});
    end
  endtask

  task automatic do_reset();
    en          = 3'b000;
    auto_grant  = 1'b0;
    grant_force = 1'b0;
    rst         = 1'b1;
    tick();
    tick();
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      exp_idx[i] = pops[i];
      fill[i]    = pops[i];
      prio[i]    = 2'd0;
      plen[i]    = 3'd0;
    end
    sb_on = 1'b1;
    rst   = 1'b0;
    tick();
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((sb.size() != 0 || req || send) && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (n >= 600 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected beats left after %0d cycles, want 0",
               name, sb.size(), n);
    end
  endtask

  task automatic set_occ(int ch, int occ);
    fill[ch] = pops[ch] + occ;
  endtask

  typedef struct packed {
    logic [2:0]      en;
    logic [2:0][1:0] prio;
    logic [2:0][2:0] plen;
    logic [2:0][5:0] occ;
    logic            req;
    logic [1:0]      ch;
    logic [5:0]      len;
  } vec_t;

  function automatic vec_t mk(logic [2:0] e,
                              int p0, int p1, int p2,
                              int l0, int l1, int l2,
                              int o0, int o1, int o2,
                              logic r, int ch, int len);
    vec_t v;
    v.en      = e;
    v.prio[0] = 2'(p0); v.prio[1] = 2'(p1); v.prio[2] = 2'(p2);
    v.plen[0] = 3'(l0); v.plen[1] = 3'(l1); v.plen[2] = 3'(l2);
    v.occ[0]  = 6'(o0); v.occ[1]  = 6'(o1); v.occ[2]  = 6'(o2);
    v.req     = r;
    v.ch      = 2'(ch);
    v.len     = 6'(len);
    return v;
  endfunction

  initial begin
    vec_t tv [10];
    int   a_before;
    int   n;
    int   beats;
    logic seen;
    logic [1:0] got_ch;
    logic [5:0] got_len;

    for (int i = 0; i < 3; i++) begin
      pops[i] = 0; fill[i] = 0; ack_total[i] = 0; exp_idx[i] = 0;
      prio[i] = 2'd0; plen[i] = 3'd0;
    end
    en = 3'b000; auto_grant = 1'b0; grant_force = 1'b0;
    grant = 1'b0; rcnt = 0; sb_on = 1'b1;

    tv[0] = mk(3'b001, 0, 0, 0, 0, 0, 0,  4,  0,  0, 1'b1, 0, 4);
    tv[1] = mk(3'b001, 0, 0, 0, 0, 0, 0,  3,  0,  0, 1'b0, 0, 0);
    tv[2] = mk(3'b011, 2, 1, 0, 0, 1, 0,  4,  8,  0, 1'b1, 1, 8);
    tv[3] = mk(3'b100, 0, 0, 0, 0, 0, 3,  0,  0, 31, 1'b0, 0, 0);
    tv[4] = mk(3'b100, 0, 0, 0, 0, 0, 3,  0,  0, 32, 1'b1, 2, 32);
    tv[5] = mk(3'b101, 0, 0, 3, 0, 0, 2,  3, 63, 16, 1'b1, 2, 16);
    tv[6] = mk(3'b110, 1, 1, 1, 0, 5, 0,  0, 63,  4, 1'b1, 1, 32);
    tv[7] = mk(3'b111, 0, 0, 0, 7, 7, 7, 32, 32, 32, 1'b1, 0, 32);
    tv[8] = mk(3'b111, 3, 2, 2, 4, 6, 1, 63, 63,  8, 1'b1, 1, 32);
    tv[9] = mk(3'b010, 0, 0, 0, 0, 2, 0,  0, 15,  0, 1'b0, 0, 0);

    tick();
    check_zero("reset_outputs");

    // arbitration table: winner and length shown while in REQ
    for (int t = 0; t < 10; t++) begin
      do_reset();
      for (int i = 0; i < 3; i++) begin
        prio[i] = tv[t].prio[i];
        plen[i] = tv[t].plen[i];
        set_occ(i, int'(tv[t].occ[i]));
      end
      grant_force = !tv[t].req;
      en = tv[t].en;
      seen = 1'b0; got_ch = '0; got_len = '0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (req || send) begin
          seen = 1'b1; got_ch = chid; got_len = flen;
        end
      end
      checks++;
      if (seen != tv[t].req ||
          (tv[t].req && (got_ch != tv[t].ch || got_len != tv[t].len))) begin
        errors++;
        $display("FAIL vec%0d: req=%b ch=%0d len=%0d, want req=%b ch=%0d len=%0d",
                 t, seen, got_ch, got_len, tv[t].req, tv[t].ch, tv[t].len);
      end
    end

    // single 4-beat packet on ch0 with req latency check
    do_reset();
    auto_grant = 1'b1;
    set_occ(0, 4);
    expect_pkt(0, 4);
    a_before = ack_total[0];
    en[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (req) begin errors++; $display("FAIL req_lat_t: req=1, want 0"); end
    @(negedge clk);
    checks++;
    if (req) begin errors++; $display("FAIL req_lat_t1: req=1, want 0"); end
    @(negedge clk);
    checks++;
    if (!req || chid != 2'd0 || flen != 6'd4) begin
      errors++;
      $display("FAIL req_lat_t2: req=%b ch=%0d len=%0d, want req=1 ch=0 len=4",
               req, chid, flen);
    end
    drain("pkt_ch0");
    checks++;
    if (ack_total[0] - a_before != 4) begin
      errors++;
      $display("FAIL ack_count: got %0d slv0 acks, want 4",
               ack_total[0] - a_before);
    end

    // priority: ch1 (prio 1) before ch0 (prio 2)
    do_reset();
    auto_grant = 1'b1;
    prio[0] = 2'd2; prio[1] = 2'd1;
    set_occ(0, 4); set_occ(1, 4);
    expect_pkt(1, 4);
    expect_pkt(0, 4);
    en = 3'b011;
    drain("prio_order");

    // equal priority tie-breaking
    do_reset();
    auto_grant = 1'b1;
    set_occ(0, 12); set_occ(1, 4); set_occ(2, 4);
`ifdef MCDF_ARB_RR_EN
    expect_pkt(0, 4); expect_pkt(1, 4); expect_pkt(2, 4);
    expect_pkt(0, 4); expect_pkt(0, 4);
`else
    expect_pkt(0, 4); expect_pkt(0, 4); expect_pkt(0, 4);
    expect_pkt(1, 4); expect_pkt(2, 4);
`endif
    en = 3'b111;
    drain("tie_order");

    // ch2 32-word packet needs occupancy 32
    do_reset();
    auto_grant = 1'b1;
    plen[2] = 3'd3;
    set_occ(2, 31);
    en[2] = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (req || send) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL occ31: req seen, want none"); end
    set_occ(2, 32);
    expect_pkt(2, 32);
    drain("occ32_pkt");

    // pkglen change mid-packet only affects the next packet
    do_reset();
    auto_grant = 1'b1;
    set_occ(0, 20);
    expect_pkt(0, 4);
    expect_pkt(0, 16);
    en[0] = 1'b1;
    n = 0;
    while (!send && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL plen_wait: send=0, want 1"); end
    plen[0] = 3'd2;
    drain("plen_change");

    // reset on beat 5 of a 16-beat packet
    do_reset();
    sb_on = 1'b0;
    auto_grant = 1'b1;
    plen[0] = 3'd2;
    set_occ(0, 16);
    en[0] = 1'b1;
    n = 0; beats = 0;
    while (beats < 5 && n < 100) begin
      @(negedge clk);
      n++;
      if (send) beats++;
    end
    tick();
    checks++;
    if (!send || !a0) begin
      errors++;
      $display("FAIL beat5: send=%b ack0=%b, want 1 1", send, a0);
    end
    rst = 1'b1;
    #1;
    check_zero("mid_pkt_reset");
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (req || send || a0 || a1 || a2) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL post_reset: activity seen, want idle");
    end
    sb_on = 1'b1;
    exp_idx[0] = pops[0];
    tick();
    set_occ(0, 16);
    expect_pkt(0, 16);
    drain("post_reset_pkt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
